// File: rtl/melody_score_sequencer.sv
// Purpose: walks a stored reference melody note by note, captures the sung pitch per window, drives the scorer and totals its scores.
// Latency: NOTE_CYCLES+SCORE_LAT+3 cycles per note; first cmp_start sampled NOTE_CYCLES+2 edges after run.
// Backpressure: none on the scorer side; enable=0 freezes all state and suppresses cmp_start.
module melody_score_sequencer #(
  parameter int NUM_NOTES   = 16,
  parameter int ADDR_W      = 4,
  parameter int NOTE_CYCLES = 1_000_000,
  parameter int SCORE_LAT   = 4,
  parameter int TOTAL_W     = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                run,
  input  logic                pitch_valid,
  input  logic [14:0]         pitch_freq,
  output logic [ADDR_W-1:0]   note_addr,
  input  logic [14:0]         note_freq_in,
  input  logic [3:0]          score_in,
  output logic                cmp_start,
  output logic [14:0]         sung_freq_out,
  output logic [14:0]         ref_freq_out,
  output logic [TOTAL_W-1:0]  total_score,
  output logic [ADDR_W:0]     note_count,
  output logic                busy,
  output logic                done
);

  localparam int WIN_W = $clog2(NOTE_CYCLES + 1);
  localparam int LAT_W = $clog2(SCORE_LAT + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(NOTE_CYCLES - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(SCORE_LAT - 1);
  localparam logic [ADDR_W:0]    CNT_LAST = (ADDR_W + 1)'(NUM_NOTES);
  localparam logic [TOTAL_W-1:0] SAT_MAX  = {TOTAL_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LISTEN, S_ISSUE, S_WAIT, S_ACCUM, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [14:0]        cap_q, cap_d;
  logic [14:0]        sung_q, sung_d;
  logic [14:0]        ref_q, ref_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;

  logic [14:0]        cap_next;
  logic [TOTAL_W:0]   sum;
  logic [ADDR_W:0]    cnt_inc;
  logic               strobe;

  // One extra bit on the sum exposes the carry used for saturation.
  assign sum     = (TOTAL_W + 1)'(total_q) + (TOTAL_W + 1)'(score_in);
  assign cnt_inc = cnt_q + 1'b1;
  // A zero-Hz report means the detector found nothing, so it never overwrites a capture.
  assign strobe  = pitch_valid && (pitch_freq != 15'd0);

  // Next-state and datapath updates; everything holds while enable is low.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    win_d     = win_q;
    lat_d     = lat_q;
    cap_d     = cap_q;
    sung_d    = sung_q;
    ref_d     = ref_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    cap_next  = cap_q;
    cmp_start = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (run) begin
            addr_d  = '0;
            total_d = '0;
            cnt_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          win_d   = '0;
          state_d = S_LISTEN;
        end
        S_LISTEN: begin
          // Window start clears the capture, but a strobe in that same cycle still lands.
          cap_next = (win_q == '0) ? 15'd0 : cap_q;
          if (strobe) cap_next = pitch_freq;
          cap_d = cap_next;
          if (win_q == '0) ref_d = note_freq_in;
          if (win_q == WIN_LAST) begin
            // Load the scorer operand now so it is already valid alongside cmp_start.
            sung_d  = cap_next;
            state_d = S_ISSUE;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
        S_ISSUE: begin
          cmp_start = 1'b1;
          lat_d     = '0;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) state_d = S_ACCUM;
          else                   lat_d   = lat_q + 1'b1;
        end
        S_ACCUM: begin
          total_d = sum[TOTAL_W] ? SAT_MAX : sum[TOTAL_W-1:0];
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset taking priority over enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      win_q   <= '0;
      lat_q   <= '0;
      cap_q   <= '0;
      sung_q  <= '0;
      ref_q   <= '0;
      total_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      lat_q   <= lat_d;
      cap_q   <= cap_d;
      sung_q  <= sung_d;
      ref_q   <= ref_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
    end
  end

  assign note_addr     = addr_q;
  assign sung_freq_out = sung_q;
  assign ref_freq_out  = ref_q;
  assign total_score   = total_q;
  assign note_count    = cnt_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);

endmodule

// File: doc/melody_score_sequencer.md
Name: melody_score_sequencer

Overview:
- Drives the pitch-comparison scorer. Steps through a stored reference melody one note at a time.
- For each note: opens a fixed listening window, captures the sung frequency from the pitch detector, then presents sung and reference frequencies with a one-cycle start pulse.
- After a fixed scorer latency, collects the 4-bit score and accumulates a song total.
- Sits between the pitch detector/melody ROM and the comparison block, on the initiator side of the start/score interface.

Parameters:
- NUM_NOTES, 16: notes per song; must be ≤ 2^ADDR_W.
- ADDR_W, 4: melody memory address width.
- NOTE_CYCLES, 1_000_000: listening-window length in clk cycles; must be ≥ 1.
- SCORE_LAT, 4: cycles from the start pulse to a valid score_in; must be ≥ 1.
- TOTAL_W, 12: width of the accumulated total.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  global enable; low freezes all state
- run  in  1  pulse; starts a song from note 0
- pitch_valid  in  1  strobe; pitch_freq is valid
- pitch_freq  in  15  detected frequency in Hz
- note_addr  out  ADDR_W  melody memory address
- note_freq_in  in  15  reference frequency in Hz; valid 1 cycle after note_addr
- score_in  in  4  score from comparison block, 0..10
- cmp_start  out  1  one-cycle start pulse to comparison block
- sung_freq_out  out  15  sung frequency to comparison block
- ref_freq_out  out  15  reference frequency to comparison block
- total_score  out  TOTAL_W  accumulated song score
- note_count  out  ADDR_W+1  notes scored so far
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  high in DONE

Behaviour:
- Reset: when reset_n=0 at a clk edge, the block enters IDLE and every output and counter clears to 0. This takes priority over enable and applies mid-song.
- enable=0:
  - State, counters and registered outputs hold.
  - cmp_start is forced to 0.
  - pitch_valid is ignored.
  - A pending ISSUE fires on the first enabled cycle.
- IDLE:
  - On run=1: note_addr←0, total_score←0, note_count←0, then go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: 1 cycle with note_addr stable, then go to LISTEN.
- LISTEN:
  - First cycle: ref_freq_out←note_freq_in, sung capture register←0, window counter←0.
  - Each cycle with pitch_valid=1 and pitch_freq≠0: capture register←pitch_freq. The last valid strobe wins, including a strobe on the final window cycle. pitch_freq=0 is ignored.
  - Stay for exactly NOTE_CYCLES cycles, then go to ISSUE.
- ISSUE:
  - sung_freq_out←capture register (0 if nothing was sung).
  - cmp_start=1 for exactly this cycle, then go to WAIT.
  - sung_freq_out and ref_freq_out stay stable from ISSUE through ACCUM.
- WAIT: count SCORE_LAT cycles, then go to ACCUM.
- ACCUM (1 cycle):
  - total_score←total_score+score_in, saturating at 2^TOTAL_W−1.
  - note_count←note_count+1.
  - If note_count+1 = NUM_NOTES, go to DONE.
  - Otherwise note_addr←note_addr+1 and go to FETCH.
- DONE:
  - done=1; total_score and note_count hold.
  - run=1 restarts exactly as from IDLE (done drops the next cycle).
- run while busy is ignored.
- Cycles per note = NOTE_CYCLES+SCORE_LAT+3.
- First cmp_start is NOTE_CYCLES+2 cycles after the run edge.
- All arithmetic is unsigned. score_in is zero-extended to TOTAL_W.

Test Plan (NOTE_CYCLES=8, SCORE_LAT=4, NUM_NOTES=3, TOTAL_W=6):
- Melody {440,880,220}, pitch_valid pulsed once per window with 440/880/220, scorer model returns 10 for each → three cmp_start pulses 15 cycles apart, first at run+10; ref_freq_out matches each note; total_score=30; done=1 with note_count=3.
- No pitch_valid during window 2 → sung_freq_out=0 at the second cmp_start; busy stays high; sequencing continues normally.
- Two pitch_valid strobes (300, then 450 on the final LISTEN cycle) → sung_freq_out=450; pitch_valid with pitch_freq=0 → capture unchanged.
- TOTAL_W=4, score_in forced to 10 for every note → total_score saturates at 15 and never wraps.
- enable low for 5 cycles during WAIT, and separately across ISSUE → cmp_start still occurs exactly once per note; all timing shifts by 5; totals unchanged. run pulsed while busy → no effect.
- reset_n=0 for 1 cycle mid-LISTEN of note 2 → next cycle: IDLE, all outputs 0; a subsequent run restarts from note_addr=0.
